// File: rtl/nlp16_pkg.sv
// Shared types and helpers for the nlp16 front end (fetch and decode).
package nlp16_pkg;

    typedef logic [15:0] word_t;

    typedef enum logic [1:0] {
        FETCH1 = 2'd0,
        FETCH2 = 2'd1,
        HOLD   = 2'd2,
        FLUSH  = 2'd3
    } fetch_state_t;

    // Bit 15 of the first word marks a two-word instruction; the decoder
    // uses the same test to select its operand source.
    function automatic logic is_two_word(word_t ir1);
        return ir1[15];
    endfunction

    // Number of words occupied by the instruction whose first word is ir1.
    function automatic word_t fetch_len(word_t ir1);
        return is_two_word(ir1) ? 16'd2 : 16'd1;
    endfunction

endpackage

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: reads 16-bit words from instruction memory,
// assembles one- or two-word instructions and hands them to the decoder
// on a valid/ready handshake. Execute can redirect the PC at any time.
module instruction_fetch
    import nlp16_pkg::*;
#(
    parameter word_t RESET_PC = 16'h0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_jmp,
    input  logic [15:0] i_jmp_addr,
    output logic [15:0] o_mem_addr,
    output logic        o_mem_rd,
    input  logic [15:0] i_mem_data,
    input  logic        i_mem_ack,
    output logic [15:0] o_ir1,
    output logic [15:0] o_ir2,
    output logic [15:0] o_pc,
    output logic        o_valid,
    input  logic        i_ready
);

    fetch_state_t state_q, state_d;
    word_t        pc_q,    pc_d;     // address of the instruction being fetched
    word_t        ir1_q,   ir1_d;
    word_t        ir2_q,   ir2_d;
    word_t        opc_q,   opc_d;    // address of the presented instruction
    word_t        addr_q,  addr_d;
    logic         rd_q,    rd_d;
    logic         valid_q, valid_d;

    logic ack;
    assign ack = rd_q & i_mem_ack;

    // Next-state logic: a redirect overrides everything except reset. The
    // memory request is never withdrawn, so a redirect that finds a read
    // still outstanding parks in FLUSH until that read completes.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir1_d   = ir1_q;
        ir2_d   = ir2_q;
        opc_d   = opc_q;
        addr_d  = addr_q;
        rd_d    = rd_q;
        valid_d = valid_q;

        if (i_jmp) begin
            pc_d    = i_jmp_addr;
            valid_d = 1'b0;
            if (rd_q && !i_mem_ack) begin
                state_d = FLUSH;
            end else begin
                state_d = FETCH1;
                rd_d    = 1'b1;
                addr_d  = i_jmp_addr;
            end
        end else begin
            case (state_q)
                FETCH1: begin
                    if (!rd_q) begin
                        // Only reachable straight out of reset: issue first read.
                        rd_d   = 1'b1;
                        addr_d = pc_q;
                    end else if (ack) begin
                        ir1_d = i_mem_data;
                        opc_d = pc_q;
                        if (is_two_word(i_mem_data)) begin
                            state_d = FETCH2;
                            addr_d  = pc_q + 16'd1;
                        end else begin
                            ir2_d   = '0;
                            rd_d    = 1'b0;
                            valid_d = 1'b1;
                            state_d = HOLD;
                        end
                    end
                end
                FETCH2: begin
                    if (ack) begin
                        ir2_d   = i_mem_data;
                        rd_d    = 1'b0;
                        valid_d = 1'b1;
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (i_ready) begin
                        pc_d    = pc_q + fetch_len(ir1_q);
                        addr_d  = pc_q + fetch_len(ir1_q);
                        rd_d    = 1'b1;
                        valid_d = 1'b0;
                        state_d = FETCH1;
                    end
                end
                FLUSH: begin
                    if (ack) begin
                        // Stale data dropped; restart at the redirect target.
                        rd_d    = 1'b1;
                        addr_d  = pc_q;
                        state_d = FETCH1;
                    end
                end
                default: begin
                    state_d = FETCH1;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= FETCH1;
            pc_q    <= RESET_PC;
            ir1_q   <= '0;
            ir2_q   <= '0;
            opc_q   <= RESET_PC;
            addr_q  <= RESET_PC;
            rd_q    <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir1_q   <= ir1_d;
            ir2_q   <= ir2_d;
            opc_q   <= opc_d;
            addr_q  <= addr_d;
            rd_q    <= rd_d;
            valid_q <= valid_d;
        end
    end

    assign o_mem_addr = addr_q;
    assign o_mem_rd   = rd_q;
    assign o_ir1      = ir1_q;
    assign o_ir2      = ir2_q;
    assign o_pc       = opc_q;
    assign o_valid    = valid_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed testbench for instruction_fetch with a model instruction memory
// that has a programmable number of wait states.
module tb_instruction_fetch;

    logic        clk;
    logic        rst;
    logic        jmp;
    logic [15:0] jmp_addr;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [15:0] mem_data;
    logic        mem_ack;
    logic [15:0] ir1;
    logic [15:0] ir2;
    logic [15:0] pc;
    logic        valid;
    logic        ready;

    logic [15:0] mem [0:65535];
    int unsigned ws;
    int unsigned wcnt;
    int unsigned n_tests;
    int unsigned n_fail;

    instruction_fetch #(.RESET_PC(16'h0000)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_jmp      (jmp),
        .i_jmp_addr (jmp_addr),
        .o_mem_addr (mem_addr),
        .o_mem_rd   (mem_rd),
        .i_mem_data (mem_data),
        .i_mem_ack  (mem_ack),
        .o_ir1      (ir1),
        .o_ir2      (ir2),
        .o_pc       (pc),
        .o_valid    (valid),
        .i_ready    (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Wait-state counter of the model memory.
    always_ff @(posedge clk) begin
        if (rst)                 wcnt <= 0;
        else if (mem_rd && !mem_ack) wcnt <= wcnt + 1;
        else                     wcnt <= 0;
    end

    assign mem_ack  = mem_rd && (wcnt >= ws);
    assign mem_data = mem_ack ? mem[mem_addr] : 16'hDEAD;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        mem[16'h0000] = 16'h1234;
        mem[16'h0001] = 16'h8001;
        mem[16'h0002] = 16'h3000;
        mem[16'h0003] = 16'h0055;
        mem[16'h0004] = 16'h8002;
        mem[16'h0005] = 16'h1111;
        mem[16'h0100] = 16'h0077;
        mem[16'hFFFF] = 16'h8000;
        rst = 1'b1; jmp = 1'b0; jmp_addr = '0; ready = 1'b1; ws = 0;

        // Reset state
        tick();
        chk("rst_valid", {15'd0, valid}, 16'd0);
        chk("rst_rd",    {15'd0, mem_rd}, 16'd0);
        chk("rst_ir1",   ir1, 16'h0000);
        chk("rst_ir2",   ir2, 16'h0000);
        chk("rst_pc",    pc, 16'h0000);
        chk("rst_addr",  mem_addr, 16'h0000);
        rst = 1'b0;

        // 1: one-word instruction
        tick();
        chk("t1_rd",    {15'd0, mem_rd}, 16'd1);
        chk("t1_addr",  mem_addr, 16'h0000);
        tick();
        chk("t1_valid", {15'd0, valid}, 16'd1);
        chk("t1_ir1",   ir1, 16'h1234);
        chk("t1_ir2",   ir2, 16'h0000);
        chk("t1_pc",    pc, 16'h0000);
        tick();
        chk("t1_next_addr",  mem_addr, 16'h0001);
        chk("t1_next_valid", {15'd0, valid}, 16'd0);

        // 2: two-word instruction
        tick();
        chk("t2_addr2", mem_addr, 16'h0002);
        chk("t2_valid_mid", {15'd0, valid}, 16'd0);
        tick();
        chk("t2_valid", {15'd0, valid}, 16'd1);
        chk("t2_ir1",   ir1, 16'h8001);
        chk("t2_ir2",   ir2, 16'h3000);
        chk("t2_pc",    pc, 16'h0001);
        ready = 1'b0;

        // 3: back-pressure in HOLD
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_valid", {15'd0, valid}, 16'd1);
            chk("t3_rd",    {15'd0, mem_rd}, 16'd0);
            chk("t3_ir1",   ir1, 16'h8001);
            chk("t3_ir2",   ir2, 16'h3000);
            chk("t3_pc",    pc, 16'h0001);
        end
        ready = 1'b1;
        tick();
        chk("t3_xfer_valid", {15'd0, valid}, 16'd0);
        chk("t3_xfer_addr",  mem_addr, 16'h0003);
        ready = 1'b0;
        tick();
        chk("t3_next_valid", {15'd0, valid}, 16'd1);
        chk("t3_next_ir1",   ir1, 16'h0055);
        chk("t3_next_pc",    pc, 16'h0003);
        tick();
        chk("t3_hold_rd",    {15'd0, mem_rd}, 16'd0);
        chk("t3_hold_pc",    pc, 16'h0003);

        // 4: redirect during a waiting FETCH2 read
        ws = 3;
        ready = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("t4_f1_addr", mem_addr, 16'h0004);
            chk("t4_f1_rd",   {15'd0, mem_rd}, 16'd1);
            tick();
        end
        tick();
        chk("t4_f2_addr",  mem_addr, 16'h0005);
        chk("t4_f2_valid", {15'd0, valid}, 16'd0);
        jmp = 1'b1; jmp_addr = 16'h0100;
        tick();
        jmp = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t4_flush_addr",  mem_addr, 16'h0005);
            chk("t4_flush_rd",    {15'd0, mem_rd}, 16'd1);
            chk("t4_flush_valid", {15'd0, valid}, 16'd0);
            tick();
        end
        chk("t4_redir_addr",  mem_addr, 16'h0100);
        chk("t4_redir_rd",    {15'd0, mem_rd}, 16'd1);
        chk("t4_redir_valid", {15'd0, valid}, 16'd0);
        ws = 0;
        tick();
        chk("t4_valid", {15'd0, valid}, 16'd1);
        chk("t4_ir1",   ir1, 16'h0077);
        chk("t4_ir2",   ir2, 16'h0000);
        chk("t4_pc",    pc, 16'h0100);

        // 5: redirect beats transfer; two-word fetch wraps past 0xFFFF
        mem[16'h0000] = 16'h00AA;
        jmp = 1'b1; jmp_addr = 16'hFFFF;
        tick();
        jmp = 1'b0;
        chk("t5_jmp_valid", {15'd0, valid}, 16'd0);
        chk("t5_jmp_addr",  mem_addr, 16'hFFFF);
        tick();
        chk("t5_wrap_addr", mem_addr, 16'h0000);
        tick();
        chk("t5_valid", {15'd0, valid}, 16'd1);
        chk("t5_ir1",   ir1, 16'h8000);
        chk("t5_ir2",   ir2, 16'h00AA);
        chk("t5_pc",    pc, 16'hFFFF);
        tick();
        chk("t5_next_addr",  mem_addr, 16'h0001);
        chk("t5_next_valid", {15'd0, valid}, 16'd0);
        tick();
        tick();
        chk("t5_after_ir1", ir1, 16'h8001);
        chk("t5_after_pc",  pc, 16'h0001);
        ready = 1'b0;

        // 6: reset while holding an instruction
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_valid", {15'd0, valid}, 16'd0);
        chk("t6_rd",    {15'd0, mem_rd}, 16'd0);
        chk("t6_ir1",   ir1, 16'h0000);
        chk("t6_pc",    pc, 16'h0000);
        tick();
        chk("t6_first_rd",   {15'd0, mem_rd}, 16'd1);
        chk("t6_first_addr", mem_addr, 16'h0000);
        tick();
        chk("t6_fetch_valid", {15'd0, valid}, 16'd1);
        chk("t6_fetch_ir1",   ir1, 16'h00AA);
        chk("t6_fetch_pc",    pc, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
